period_meter: RTL and testbench
===============================

# period_meter

Measures the period of the resonant-tank zero-crossing square wave in `clk` cycles and presents it to the downstream pipelined divider as a dividend/divisor pair with a valid strobe. The divider turns the pair into a frequency figure for the SWIPT frequency-tracking loop. The block synchronises the asynchronous comparator input, rejects glitches, optionally averages several periods, and flags loss of signal.

## Interface
- `XLEN`, 32, data width; matches divider width.
- `CLK_HZ`, 100000000, `clk` frequency in Hz; used as the dividend.
- `SYNC_STAGES`, 2, synchroniser flops on `sig_in`; minimum 2.
- `MIN_PERIOD`, 8, shortest accepted period in cycles; shorter edge spacing is a glitch.
- `TIMEOUT`, 1000000, cycles without an accepted edge before loss of signal; `TIMEOUT < 2**(XLEN-AVG_LOG2)`.
- `AVG_LOG2`, 2, log2 of periods averaged; used only with `PERIOD_METER_AVG_EN`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: asynchronous, active-high.
- `en`  in  1  measurement enable; synchronous.
- `sig_in`  in  1  asynchronous zero-crossing comparator output.
- `a`  out  XLEN  dividend to divider; constant scaled clock rate.
- `b`  out  XLEN  divisor to divider; measured (summed) period in cycles.
- `vld`  out  1  one-cycle strobe; `a`/`b` valid this cycle.
- `lost`  out  1  level; high from timeout until the next emitted measurement.
- `locked`  out  1  level; high while in MEASURE.

## Operation
- States:
  - IDLE: `en`=0.
  - ARM: wait for the first rising edge.
  - MEASURE: counting periods.
- Transitions:
  - IDLE→ARM when `en`=1.
  - ARM→MEASURE on a rising edge. This loads `cnt`←1 and clears `acc` and `k`.
  - MEASURE→ARM on timeout.
  - Any state→IDLE when `en`=0. This clears `cnt`, `acc` and `k`, and no `vld` is issued.
- Edge detection: rising edge = synchronised sample is 1 and the previous sample is 0.
- Counting in MEASURE: `cnt` increments by 1 every cycle, saturating at `2**XLEN-1`. At an edge cycle, `cnt` equals the period P in cycles.
- Accepted edge (P ≥ `MIN_PERIOD`):
  - `acc`←`acc`+P and `cnt`←1.
  - If this completes the measurement set, issue `vld`, clear `acc` and `k`, and clear `lost`.
- Glitch edge (P < `MIN_PERIOD`): ignored; `cnt` keeps counting and nothing else changes.
- Timeout: `cnt` == `TIMEOUT` with no edge that cycle. Set `lost`=1, go to ARM, discard `acc`, no `vld`.
- Edge and timeout in the same cycle: the edge wins.
- Output values:
  - `a` = `CLK_HZ << AVG_LOG2` with averaging, else `CLK_HZ`.
  - `b` holds the last emitted sum; it never presents 0 with `vld`.
  - `a`/`b` are registered and held between strobes.
- The divider has no backpressure; every `vld` is consumed.

## Timing
- Reset values: `a`=0, `b`=0, `vld`=0, `lost`=0, `locked`=0; state IDLE; `cnt`=0, `acc`=0.
- `sig_in`→edge detected: `SYNC_STAGES`+1 cycles.
- Edge detected at cycle t completing a set → `vld`=1 at t+1 with the new `b`.
- Minimum `vld` spacing: `MIN_PERIOD` cycles (no averaging) or `MIN_PERIOD << AVG_LOG2` (averaging).
- `locked` is registered and equals (state==MEASURE).
- `rst` asserted mid-measurement: all registers return to reset values immediately. After release, the block restarts from IDLE.

## Configuration
- `PERIOD_METER_AVG_EN` defined:
  - Accumulate `2**AVG_LOG2` accepted periods (`k` counts to `2**AVG_LOG2-1`), then emit.
  - `b` = sum, `a` = `CLK_HZ << AVG_LOG2`.
  - An elaboration check enforces `CLK_HZ << AVG_LOG2 < 2**XLEN`.
- Undefined:
  - Every accepted period is emitted.
  - `b` = P, `a` = `CLK_HZ`.
  - No `k` counter and no `acc` adder are built.

## Structure
- Shared package `swipt_pkg`:
  - State enum `pm_state_t` (IDLE, ARM, MEASURE).
  - Default `XLEN` and `CLK_HZ` constants, shared with the divider instance.
- One sub-module: `swipt_edge_sync`, parameterised by `SYNC_STAGES`. It contains the synchroniser chain and the rising-edge detector, and outputs a one-cycle `rise` pulse.

## Test plan
- 100 cycles of reset, then `rst` released with `en`=0 → all outputs 0, state IDLE, no `vld`.
- No averaging, `en`=1, `sig_in` square wave of period 100 → first `vld` after the second edge with `b`=100, `a`=`CLK_HZ`, then `vld` every 100 cycles.
- Averaging with `AVG_LOG2`=2, periods 100, 102, 98, 100 → one `vld` with `b`=400, `a`=400000000; no earlier strobes.
- 3-cycle glitch pulse inserted inside a period of 100 → glitch ignored, `b`=100, no extra `vld`.
- `sig_in` stuck low for `TIMEOUT`+10 cycles → `lost`=1 and `locked`=0 at timeout, no `vld`. After the square wave resumes, `lost` clears on the next `vld`.
- `en` dropped, or `rst` pulsed, mid-period → no `vld`, accumulator cleared. The next measurement starts fresh and `b` equals the true period.

Source files
------------

// File: rtl/swipt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : swipt_pkg
// Brief    : Shared SWIPT constants and the period_meter state type.
// Revision : 1.0  initial release
// ============================================================================
package swipt_pkg;

    // Defaults shared with the downstream divider instance
    localparam int unsigned c_xlen   = 32;
    localparam int unsigned c_clk_hz = 100000000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } pm_state_t;

endpackage
`default_nettype wire

// File: rtl/swipt_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : swipt_edge_sync
// Brief    : Synchroniser chain plus registered rising-edge detector.
// Revision : 1.0  initial release
// ============================================================================
module swipt_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("swipt_edge_sync: SYNC_STAGES must be at least 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
// Module   : period_meter
// Brief    : Zero-crossing period meter feeding a dividend/divisor pair to the
//            frequency divider. Define PERIOD_METER_AVG_EN to sum 2**AVG_LOG2
//            periods per measurement.
// Revision : 1.0  initial release
// ============================================================================
module period_meter
    import swipt_pkg::*;
#(
    parameter int unsigned XLEN        = c_xlen,
    parameter int unsigned CLK_HZ      = c_clk_hz,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_PERIOD  = 8,
    parameter int unsigned TIMEOUT     = 1000000,
    parameter int unsigned AVG_LOG2    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            sig_in,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic            vld,
    output logic            lost,
    output logic            locked
);

    generate
        if (64'(TIMEOUT) >= (64'd1 << (XLEN - AVG_LOG2))) begin : g_bad_timeout
            $error("period_meter: TIMEOUT must be below 2**(XLEN-AVG_LOG2)");
        end
    endgenerate

`ifdef PERIOD_METER_AVG_EN
    generate
        if (AVG_LOG2 < 1) begin : g_bad_avg_log2
            $error("period_meter: AVG_LOG2 must be at least 1 when averaging");
        end
        if ((64'(CLK_HZ) << AVG_LOG2) >= (64'd1 << XLEN)) begin : g_bad_clk_hz
            $error("period_meter: CLK_HZ << AVG_LOG2 overflows XLEN");
        end
    endgenerate
    localparam logic [XLEN-1:0] c_a = XLEN'(64'(CLK_HZ) << AVG_LOG2);
`else
    localparam logic [XLEN-1:0] c_a = XLEN'(CLK_HZ);
`endif

    localparam logic [XLEN-1:0] c_one     = XLEN'(1);
    localparam logic [XLEN-1:0] c_min     = XLEN'(MIN_PERIOD);
    localparam logic [XLEN-1:0] c_timeout = XLEN'(TIMEOUT);

    pm_state_t       r_state;
    pm_state_t       w_state_nxt;
    logic [XLEN-1:0] r_cnt;
    logic [XLEN-1:0] w_cnt_inc;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic            r_vld;
    logic            r_lost;
    logic            r_locked;
    logic            w_rise;
    logic            w_accept;
    logic            w_to;
    logic [XLEN-1:0] w_sum;
    logic            w_done;

    swipt_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk   (clk),
        .rst   (rst),
        .sig_in(sig_in),
        .rise  (w_rise)
    );

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + c_one;
    assign w_accept  = (r_cnt >= c_min);
    // A rising edge in the timeout cycle takes priority over the timeout
    assign w_to      = (r_cnt == c_timeout) && !w_rise;

`ifdef PERIOD_METER_AVG_EN
    logic [XLEN-1:0]     r_acc;
    logic [AVG_LOG2-1:0] r_k;

    assign w_sum  = r_acc + r_cnt;
    assign w_done = (r_k == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_k   <= '0;
        end else if (!en || r_state != MEASURE || w_to) begin
            r_acc <= '0;
            r_k   <= '0;
        end else if (w_rise && w_accept) begin
            if (w_done) begin
                r_acc <= '0;
                r_k   <= '0;
            end else begin
                r_acc <= w_sum;
                r_k   <= r_k + AVG_LOG2'(1);
            end
        end
    end
`else
    assign w_sum  = r_cnt;
    assign w_done = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = ARM;
                ARM:     if (w_rise) w_state_nxt = MEASURE;
                MEASURE: if (w_to)   w_state_nxt = ARM;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_locked <= 1'b0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_vld    <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_locked <= (w_state_nxt == MEASURE);
            r_vld    <= 1'b0;
            if (!en) begin
                r_cnt <= '0;
            end else begin
                case (r_state)
                    ARM: begin
                        if (w_rise) r_cnt <= c_one;
                    end
                    MEASURE: begin
                        if (w_rise && w_accept) begin
                            r_cnt <= c_one;
                            if (w_done) begin
                                r_vld  <= 1'b1;
                                r_a    <= c_a;
                                r_b    <= w_sum;
                                r_lost <= 1'b0;
                            end
                        end else if (w_to) begin
                            r_cnt  <= '0;
                            r_lost <= 1'b1;
                        end else begin
                            // Glitch edges fall through here and keep counting
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: r_cnt <= '0;
                endcase
            end
        end
    end

    assign a      = r_a;
    assign b      = r_b;
    assign vld    = r_vld;
    assign lost   = r_lost;
    assign locked = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_period_meter
// Brief    : Randomised scoreboard bench for period_meter with an edge-level
//            reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_period_meter;

    localparam int XLEN   = 32;
    localparam int CLK_HZ = 100000000;
    localparam int SYNC   = 2;
    localparam int MINP   = 8;
    localparam int TMO    = 2000;
    localparam int AVG    = 2;
`ifdef PERIOD_METER_AVG_EN
    localparam int    NAVG  = 1 << AVG;
    localparam longint A_EXP = longint'(CLK_HZ) << AVG;
`else
    localparam int    NAVG  = 1;
    localparam longint A_EXP = longint'(CLK_HZ);
`endif

    logic            clk    = 1'b0;
    logic            rst    = 1'b1;
    logic            en     = 1'b0;
    logic            sig_in = 1'b0;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            vld;
    logic            lost;
    logic            locked;

    always #5 clk = ~clk;

    period_meter #(
        .XLEN       (XLEN),
        .CLK_HZ     (CLK_HZ),
        .SYNC_STAGES(SYNC),
        .MIN_PERIOD (MINP),
        .TIMEOUT    (TMO),
        .AVG_LOG2   (AVG)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .sig_in(sig_in),
        .a     (a),
        .b     (b),
        .vld   (vld),
        .lost  (lost),
        .locked(locked)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint a;
        longint b;
    } exp_t;
    exp_t q[$];

    // Reference model works on the times at which sig_in rises
    bit     m_en   = 0;
    bit     m_meas = 0;
    bit     m_lost = 0;
    longint m_last = 0;
    longint m_acc  = 0;
    int     m_k    = 0;

    function automatic void model_edge(longint t);
        exp_t e;
        longint p;
        if (!m_en) return;
        if (m_meas && (t - m_last) > TMO) begin
            m_meas = 0;
            m_lost = 1;
        end
        if (!m_meas) begin
            m_meas = 1;
            m_last = t;
            m_acc  = 0;
            m_k    = 0;
        end else begin
            p = t - m_last;
            if (p >= MINP) begin
                m_last = t;
                m_acc  = m_acc + p;
                m_k    = m_k + 1;
                if (m_k == NAVG) begin
                    e.a = A_EXP;
                    e.b = m_acc;
                    q.push_back(e);
                    m_acc  = 0;
                    m_k    = 0;
                    m_lost = 0;
                end
            end
        end
    endfunction

    function automatic void model_timeout();
        if (m_meas && (cyc - m_last) > TMO + 5) begin
            m_meas = 0;
            m_lost = 1;
            m_acc  = 0;
            m_k    = 0;
        end
    endfunction

    function automatic void model_clear(bit clr_lost);
        m_meas = 0;
        m_acc  = 0;
        m_k    = 0;
        if (clr_lost) m_lost = 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (vld === 1'b1) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_vld: got vld with b=%0d expected no strobe (t=%0t)", b, $time);
            end else begin
                e = q.pop_front();
                chk("vld_b", 64'(b), 64'(e.b));
                chk("vld_a", 64'(a), 64'(e.a));
                chk("vld_lost", 64'(lost), 64'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rise_now();
        sig_in = 1'b1;
        model_edge(cyc);
    endtask

    task automatic wave(input int p, input int h);
        rise_now();
        tick(h);
        sig_in = 1'b0;
        tick(p - h);
    endtask

    // Short low dip right after the true edge re-rises inside MIN_PERIOD
    task automatic glitch_wave(input int p);
        rise_now();
        tick(2);
        sig_in = 1'b0;
        tick(3);
        rise_now();
        tick(45);
        sig_in = 1'b0;
        tick(p - 50);
    endtask

    task automatic random_waves(input int n);
        int p;
        int h;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) p = $urandom_range(2, MINP - 1);
            else                            p = $urandom_range(MINP, 250);
            h = $urandom_range(1, p - 1);
            wave(p, h);
        end
    endtask

    initial begin
        tick(100);
        rst = 1'b0;
        tick(5);
        chk("reset_a", 64'(a), 64'd0);
        chk("reset_b", 64'(b), 64'd0);
        chk("reset_vld", 64'(vld), 64'd0);
        chk("reset_lost", 64'(lost), 64'd0);
        chk("reset_locked", 64'(locked), 64'd0);
        tick(50);

        en   = 1'b1;
        m_en = 1;
        tick(10);
        chk("arm_locked", 64'(locked), 64'd0);
        for (int i = 0; i < 6; i++) wave(100, 50);
        chk("measure_locked", 64'(locked), 64'd1);

        // Drop enable mid-period, then a fresh 100/102/98/100 set
        rise_now();
        tick(20);
        sig_in = 1'b0;
        tick(20);
        en   = 1'b0;
        m_en = 0;
        model_clear(0);
        tick(10);
        chk("idle_locked", 64'(locked), 64'd0);
        en   = 1'b1;
        m_en = 1;
        tick(10);
        wave(100, 50);
        wave(102, 51);
        wave(98, 49);
        wave(100, 50);
        wave(100, 50);

        glitch_wave(100);
        glitch_wave(100);
        wave(100, 50);

        random_waves(40);

        // Loss of signal
        tick(TMO + 10);
        model_timeout();
        chk("timeout_lost", 64'(lost), 64'(m_lost));
        chk("timeout_locked", 64'(locked), 64'd0);
        wave(100, 50);
        chk("rearm_lost", 64'(lost), 64'(m_lost));
        chk("rearm_locked", 64'(locked), 64'd1);
        for (int i = 0; i < 5; i++) wave(100, 50);
        chk("resume_lost", 64'(lost), 64'(m_lost));

        // Asynchronous reset mid-period
        rise_now();
        tick(20);
        sig_in = 1'b0;
        tick(20);
        rst = 1'b1;
        model_clear(1);
        #1;
        chk("rst_async_locked", 64'(locked), 64'd0);
        chk("rst_async_b", 64'(b), 64'd0);
        chk("rst_async_a", 64'(a), 64'd0);
        tick(5);
        rst = 1'b0;
        tick(10);
        wave(137, 60);
        for (int i = 0; i < 8; i++) wave(137, 60);
        random_waves(30);

        tick(20);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
